// File: rtl/nco_poly.sv
// Time-multiplexed polyphonic NCO: one shared lookup/interpolate datapath walks
// all voices per sample tick and sums them into a single mixed sample.

module nco_voice #(
  parameter int PHASE_W = 32
) (
  input  logic               master_clk,
  input  logic               rst_n,
  input  logic               i_cfg_hit,
  input  logic [PHASE_W-1:0] i_cfg_incr,
  input  logic               i_cfg_gate,
  input  logic               i_step,
  output logic [PHASE_W-1:0] o_phase,
  output logic               o_gate
);
  logic [PHASE_W-1:0] r_incr;

  // A config write outranks a same-cycle phase step; a gate edge retriggers.
  always_ff @(posedge master_clk or negedge rst_n) begin
    if (!rst_n) begin
      o_phase <= '0;
      r_incr  <= '0;
      o_gate  <= 1'b0;
    end else if (i_cfg_hit) begin
      r_incr <= i_cfg_incr;
      o_gate <= i_cfg_gate;
      if (i_cfg_gate != o_gate) o_phase <= '0;
    end else if (i_step && o_gate) begin
      o_phase <= o_phase + r_incr;
    end
  end
endmodule

module nco_poly #(
  parameter int NUM_VOICES   = 4,
  parameter int PHASE_W      = 32,
  parameter int TABLE_ADDR_W = 5,
  parameter int FRAC_W       = 8,
  parameter int SAMPLE_W     = 16,
  localparam int VW          = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1,
  localparam int MIX_W       = SAMPLE_W + $clog2(NUM_VOICES)
) (
  input  logic                       master_clk,
  input  logic                       rst_n,
  input  logic                       sample_tick,
  input  logic                       cfg_we,
  input  logic [VW-1:0]              cfg_voice,
  input  logic [PHASE_W-1:0]         cfg_incr,
  input  logic                       cfg_gate,
  input  logic                       tbl_we,
  input  logic                       tbl_sel,
  input  logic [TABLE_ADDR_W-1:0]    tbl_addr,
  input  logic signed [SAMPLE_W-1:0] tbl_data,
  output logic signed [MIX_W-1:0]    mix_out,
  output logic                       mix_valid,
  output logic                       busy,
  output logic                       overrun
);
  typedef enum logic [2:0] {IDLE, ACCUM, LOOKUP, INTERP, DONE} state_t;

  state_t r_state, w_state_nxt;
  logic [VW-1:0]                       r_v;
  logic signed [MIX_W-1:0]             r_acc;
  logic signed [SAMPLE_W-1:0]          r_wave, r_slope;
  logic [FRAC_W-1:0]                   r_frac;
  logic signed [SAMPLE_W-1:0]          r_wtbl [1<<TABLE_ADDR_W];
  logic signed [SAMPLE_W-1:0]          r_stbl [1<<TABLE_ADDR_W];

  logic [NUM_VOICES-1:0][PHASE_W-1:0] w_phase;
  logic [NUM_VOICES-1:0]              w_gate;
  logic [PHASE_W-1:0]                 w_phase_cur;
  logic [TABLE_ADDR_W-1:0]            w_idx;
  logic                               w_start, w_last;
  logic signed [SAMPLE_W+FRAC_W:0]    w_prod, w_sh;
  logic signed [SAMPLE_W-1:0]         w_s;
  logic signed [MIX_W-1:0]            w_add, w_acc_nxt;

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    nco_voice #(.PHASE_W(PHASE_W)) u_voice (
      .master_clk (master_clk),
      .rst_n      (rst_n),
      .i_cfg_hit  (cfg_we && (cfg_voice == VW'(i))),
      .i_cfg_incr (cfg_incr),
      .i_cfg_gate (cfg_gate),
      .i_step     ((r_state == ACCUM) && (r_v == VW'(i))),
      .o_phase    (w_phase[i]),
      .o_gate     (w_gate[i])
    );
  end

  assign busy        = (r_state == ACCUM) || (r_state == LOOKUP) || (r_state == INTERP);
  assign mix_valid   = (r_state == DONE);
  assign overrun     = sample_tick && busy;
  assign w_start     = sample_tick && !busy;
  assign w_last      = (r_v == VW'(NUM_VOICES - 1));
  assign w_phase_cur = w_phase[r_v];
  assign w_idx       = w_phase_cur[PHASE_W-1 -: TABLE_ADDR_W];

  // Interpolate with a signed slope times an unsigned fraction; wrap to SAMPLE_W.
  assign w_prod    = r_slope * $signed({1'b0, r_frac});
  assign w_sh      = w_prod >>> FRAC_W;
  assign w_s       = r_wave + w_sh[SAMPLE_W-1:0];
  assign w_add     = w_gate[r_v] ? MIX_W'(w_s) : '0;
  assign w_acc_nxt = r_acc + w_add;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: w_state_nxt = sample_tick ? ACCUM : IDLE;
      ACCUM:      w_state_nxt = LOOKUP;
      LOOKUP:     w_state_nxt = INTERP;
      INTERP:     w_state_nxt = w_last ? DONE : ACCUM;
      default:    w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge master_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_v     <= '0;
      r_acc   <= '0;
      r_wave  <= '0;
      r_slope <= '0;
      r_frac  <= '0;
      mix_out <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_v   <= '0;
        r_acc <= '0;
      end
      if (r_state == LOOKUP) begin
        r_wave  <= r_wtbl[w_idx];
        r_slope <= r_stbl[w_idx];
        r_frac  <= w_phase_cur[PHASE_W-TABLE_ADDR_W-1 -: FRAC_W];
      end
      if (r_state == INTERP) begin
        r_acc <= w_acc_nxt;
        if (w_last) mix_out <= w_acc_nxt;
        else        r_v     <= r_v + 1'b1;
      end
    end
  end

  // Table storage is not reset; reads in LOOKUP see pre-write contents.
  always_ff @(posedge master_clk) begin
    if (tbl_we) begin
      if (tbl_sel) r_stbl[tbl_addr] <= tbl_data;
      else         r_wtbl[tbl_addr] <= tbl_data;
    end
  end
endmodule

// File: tb/tb_nco_poly.sv
// Randomized and directed checks of nco_poly against an arithmetic voice model.

module tb_nco_poly;
  localparam int NV = 4, PW = 32, AW = 5, FW = 8, SW = 16, MW = 18;

  logic                 master_clk = 1'b0;
  logic                 rst_n, sample_tick, cfg_we, cfg_gate, tbl_we, tbl_sel;
  logic [1:0]           cfg_voice;
  logic [PW-1:0]        cfg_incr;
  logic [AW-1:0]        tbl_addr;
  logic signed [SW-1:0] tbl_data;
  logic signed [MW-1:0] mix_out;
  logic                 mix_valid, busy, overrun;

  nco_poly #(.NUM_VOICES(NV), .PHASE_W(PW), .TABLE_ADDR_W(AW), .FRAC_W(FW), .SAMPLE_W(SW)) dut (
    .master_clk(master_clk), .rst_n(rst_n), .sample_tick(sample_tick),
    .cfg_we(cfg_we), .cfg_voice(cfg_voice), .cfg_incr(cfg_incr), .cfg_gate(cfg_gate),
    .tbl_we(tbl_we), .tbl_sel(tbl_sel), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .mix_out(mix_out), .mix_valid(mix_valid), .busy(busy), .overrun(overrun)
  );

  always #5 master_clk = ~master_clk;

  int n_chk = 0, n_fail = 0;
  bit [PW-1:0] m_phase [NV];
  bit [PW-1:0] m_incr  [NV];
  bit          m_gate  [NV];
  int          m_wave  [1<<AW];
  int          m_slope [1<<AW];

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge master_clk); #1;
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_phase[v] = '0; m_incr[v] = '0; m_gate[v] = 1'b0;
    end
  endtask

  // One frame of the reference: advance gated phases, look up, interpolate, sum.
  function automatic int model_frame();
    int sum = 0;
    for (int v = 0; v < NV; v++) begin
      if (m_gate[v]) begin
        int idx, fr, s;
        shortint s16;
        m_phase[v] = m_phase[v] + m_incr[v];
        idx = int'(m_phase[v][PW-1 -: AW]);
        fr  = int'(m_phase[v][PW-AW-1 -: FW]);
        s   = m_wave[idx] + ((m_slope[idx] * fr) >>> FW);
        s16 = shortint'(s);
        sum += int'(s16);
      end
    end
    return sum;
  endfunction

  task automatic cfg(input int v, input bit [PW-1:0] incr, input bit gate);
    cfg_we = 1'b1; cfg_voice = 2'(v); cfg_incr = incr; cfg_gate = gate;
    step();
    cfg_we = 1'b0;
    if (gate != m_gate[v]) m_phase[v] = '0;
    m_incr[v] = incr; m_gate[v] = gate;
  endtask

  task automatic twr(input bit sel, input int addr, input int data);
    shortint d16;
    d16 = shortint'(data);
    tbl_we = 1'b1; tbl_sel = sel; tbl_addr = AW'(addr); tbl_data = d16;
    step();
    tbl_we = 1'b0;
    if (sel) m_slope[addr] = int'(d16);
    else     m_wave[addr]  = int'(d16);
  endtask

  task automatic frame(input string tag, output int obs);
    int exp, n;
    exp = model_frame();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    n = 1;
    chk({tag, "_busy"}, int'(busy), 1);
    while (!mix_valid && n < 40) begin
      step(); n++;
    end
    chk({tag, "_lat"}, n, 3*NV + 1);
    obs = int'(mix_out);
    chk(tag, obs, exp);
    step();
    chk({tag, "_hold"}, int'(mix_out), exp);
  endtask

  initial begin
    int obs, nv, vat, nov, oat, exp;
    rst_n = 1'b0; sample_tick = 0; cfg_we = 0; cfg_voice = 0; cfg_incr = 0; cfg_gate = 0;
    tbl_we = 0; tbl_sel = 0; tbl_addr = 0; tbl_data = 0;
    model_reset();
    #22 rst_n = 1'b1;
    step();
    chk("rst_mix", int'(mix_out), 0);
    chk("rst_vld", int'(mix_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovr", int'(overrun), 0);

    for (int i = 0; i < (1<<AW); i++) begin
      twr(1'b0, i, 1024*i);
      twr(1'b1, i, 1024);
    end
    frame("off", obs);

    // Step through the whole table including the phase wrap back to entry 0.
    cfg(0, 32'h0800_0000, 1'b1);
    for (int k = 1; k <= 32; k++) begin
      frame("step", obs);
      chk("step_const", obs, (1024*k) % 32768);
    end

    // Retrigger via gate off/on; half-step increments exercise frac=0x80.
    cfg(0, 32'h0400_0000, 1'b0);
    cfg(0, 32'h0400_0000, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      frame("interp", obs);
      chk("interp_const", obs, 512*k);
    end

    for (int i = 0; i < (1<<AW); i++) begin
      twr(1'b0, i, -32768);
      twr(1'b1, i, 0);
    end
    for (int v = 0; v < NV; v++) cfg(v, $urandom, 1'b1);
    frame("full", obs);
    chk("full_const", obs, -131072);
    cfg(2, 32'h1234_5678, 1'b0);
    frame("less", obs);
    chk("less_const", obs, -98304);

    for (int i = 0; i < (1<<AW); i++) begin
      twr(1'b0, i, int'($urandom_range(0, 65535)) - 32768);
      twr(1'b1, i, int'($urandom_range(0, 65535)) - 32768);
    end
    for (int v = 0; v < NV; v++) cfg(v, $urandom, 1'($urandom));
    for (int f = 0; f < 12; f++) begin
      cfg(int'($urandom_range(0, NV-1)), $urandom, 1'($urandom));
      frame("rand", obs);
    end

    // Second tick five cycles into a frame must only flag overrun.
    exp = model_frame();
    sample_tick = 1'b1;
    #1 chk("ovr_idle", int'(overrun), 0);
    step();
    sample_tick = 1'b0;
    nov = 0; oat = -1; nv = 0; vat = -1;
    for (int c = 1; c <= 20; c++) begin
      if (c == 5) sample_tick = 1'b1;
      #1;
      if (overrun)   begin nov++; oat = c; end
      if (mix_valid) begin nv++;  vat = c; end
      step();
      sample_tick = 1'b0;
    end
    chk("ovr_cnt", nov, 1);
    chk("ovr_at", oat, 5);
    chk("ovr_vld_cnt", nv, 1);
    chk("ovr_vld_at", vat, 3*NV + 1);
    chk("ovr_mix", int'(mix_out), exp);

    // Asynchronous reset in the middle of a frame.
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_mix", int'(mix_out), 0);
    chk("mrst_vld", int'(mix_valid), 0);
    model_reset();
    step();
    rst_n = 1'b1;
    nv = 0;
    for (int c = 0; c < 20; c++) begin
      if (mix_valid) nv++;
      step();
    end
    chk("mrst_novld", nv, 0);
    frame("post_rst", obs);
    chk("post_rst_const", obs, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/nco_poly.md
Name: nco_poly

Overview:
- Time-multiplexed polyphonic numerically controlled oscillator. One shared datapath serves NUM_VOICES voices.
- Each voice has its own phase accumulator, increment register and gate.
- On every sample tick the block steps each gated voice's phase and reads a shared, runtime-loadable wavetable and slope table. It linearly interpolates between entries and sums all voices into one mixed sample for the downstream DAC/mixer stage.

Parameters:
- NUM_VOICES, 4, number of voices (>=1).
- PHASE_W, 32, phase accumulator width.
- TABLE_ADDR_W, 5, wavetable index width (2^TABLE_ADDR_W entries).
- FRAC_W, 8, phase bits below the index used as the interpolation fraction.
- SAMPLE_W, 16, signed table entry and per-voice sample width.

Ports:
- master_clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sample_tick  in  1  one-cycle request to compute one output frame.
- cfg_we  in  1  voice config write strobe.
- cfg_voice  in  clog2(NUM_VOICES)  voice being configured.
- cfg_incr  in  PHASE_W  phase increment for that voice.
- cfg_gate  in  1  voice enable.
- tbl_we  in  1  table write strobe.
- tbl_sel  in  1  table select: 0 = wavetable, 1 = slope table.
- tbl_addr  in  TABLE_ADDR_W  table entry address.
- tbl_data  in  SAMPLE_W  signed table entry.
- mix_out  out  SAMPLE_W+clog2(NUM_VOICES)  signed sum of voices.
- mix_valid  out  1  one-cycle pulse; mix_out is new.
- busy  out  1  frame in progress.
- overrun  out  1  one-cycle pulse; sample_tick arrived while busy.

Behaviour:
- Clock and reset: single clock master_clk. Reset is asynchronous active-low on rst_n.
- Reset values: all phases, increments and gates are 0. mix_out=0, mix_valid=0, busy=0, overrun=0, FSM in IDLE. Table contents are not reset.
- FSM states: IDLE, ACCUM, LOOKUP, INTERP, DONE. Voice index v is a counter.
- Start: sample_tick is accepted when busy=0, i.e. in IDLE or DONE. The next state is ACCUM with v=0.
- Per voice, 3 cycles:
  - ACCUM: if gate[v]=1, phase[v] <= phase[v] + incr[v], wrapping modulo 2^PHASE_W.
  - LOOKUP: idx = phase[v][PHASE_W-1 -: TABLE_ADDR_W]; frac = next FRAC_W bits, unsigned. Register wave[idx] and slope[idx].
  - INTERP: s = wave + ((slope * frac) >>> FRAC_W), with a signed product. Truncate s to SAMPLE_W (wrap, no saturation). If gate[v]=1, add s to the sign-extended mix accumulator; otherwise add 0.
  - Then v increments and the FSM returns to ACCUM, or goes to DONE after the last voice.
- Mix accumulator: cleared on frame start.
- DONE: mix_out <= accumulator and mix_valid=1 for exactly one cycle.
- Timing: for a tick accepted in cycle T, busy=1 in cycles T+1..T+3N and 0 in DONE. mix_valid is asserted in cycle T+3N+1. DONE goes to IDLE unless a tick is present.
- Overrun: sample_tick while busy=1 is ignored, overrun=1 that cycle, and the frame continues unaffected.
- Config writes: accepted any cycle and take effect next cycle.
  - incr and gate are updated.
  - If the written gate value differs from the current one (either edge), phase[v] is cleared to 0.
  - On collision with ACCUM of the same voice in the same cycle, the config write wins: phase is cleared, or holds if the gate is unchanged.
  - A voice uses the values present at its own ACCUM/INTERP cycles.
- Table writes: accepted any cycle. A read of the same address in the same cycle returns the old data.
- Gated-off voice: phase is frozen and contributes 0.
- Reset mid-frame: immediate return to IDLE with all reset values. No mix_valid for the aborted frame.
- mix_out holds its value between frames.

Test Plan:
- Reset: assert rst_n=0 mid-frame -> all outputs 0 immediately. After release, a tick with all gates off gives mix_out=0 and mix_valid at T+13 (N=4).
- Table step: wave[i]=1024*i, slope[i]=1024; voice0 gate=1, incr=0x0800_0000; others off. Successive frames give mix_out=1024, 2048, …, 31744, then 0 on the 32nd (phase wrap).
- Interpolation: same tables, incr=0x0400_0000 -> mix_out=512, 1024, 1536, 2048 (frac=0x80 adds slope/2).
- Full mix and sign: all wave=-32768, slope=0, four voices gated with any incr -> mix_out=-131072. Then gate voice2 off -> -98304.
- Overrun: tick at T and T+5 -> overrun pulse at T+5 only, and a single mix_valid at T+13.
- Gate retrigger: voice0 running with phase≠0; write cfg_gate=0 then 1 -> phase cleared. The next frame outputs wave[0]+interpolated step from phase=incr.
